sensor_sample_ctrl: RTL and testbench



---
 rtl/sensor_node_pkg.sv | 13 +
 rtl/sample_fifo.sv | 61 ++++++
 rtl/sensor_sample_ctrl.sv | 106 ++++++++++
 tb/tb_sensor_sample_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/sensor_node_pkg.sv
// Shared definitions for sensor node controllers: sample width and sampling FSM states.
package sensor_node_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_WAIT    = 2'd3
  } state_e;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample buffer; a push into a full buffer is accepted only when a pop happens on the same edge.
module sample_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign full_o  = (count_q == CW'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || pop_i);
  // Head reads as zero while empty so the output is clean straight out of reset.
  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = (rd_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/sensor_sample_ctrl.sv
// Periodic sensor sampler: pulses sensor_en, captures a byte into a FIFO, and flags alarm/overflow.
module sensor_sample_ctrl
  import sensor_node_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 8,
  parameter int SETTLE_CYCLES = 2,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              sensor_en,
  input  logic [DATA_W-1:0] sensor_data,
  input  logic [DATA_W-1:0] threshold,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              alarm,
  output logic              overflow,
  output logic              busy
);

  localparam int WAIT_CYCLES = SAMPLE_PERIOD - SETTLE_CYCLES - 1;
  localparam int CNT_W       = $clog2(SAMPLE_PERIOD + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sensor_en_q;
  logic               alarm_q, overflow_q;
  logic               capture, pop, fifo_full, fifo_empty;

  assign capture   = (state_q == ST_CAPTURE);
  assign tx_valid  = !fifo_empty;
  assign pop       = tx_valid && tx_ready;
  assign sensor_en = sensor_en_q;
  assign alarm     = alarm_q;
  assign overflow  = overflow_q;
  assign busy      = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_d = ST_CAPTURE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_CAPTURE: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        // start is sampled only here, so a drop earlier still finishes the current sample.
        if (cnt_q == CNT_W'(WAIT_CYCLES - 1)) begin
          state_d = start ? ST_SETTLE : ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sensor_en_q <= 1'b0;
      alarm_q     <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sensor_en_q <= (state_d == ST_SETTLE) || (state_d == ST_CAPTURE);
      if (capture) alarm_q <= (sensor_data >= threshold);
      if (capture && fifo_full && !pop) overflow_q <= 1'b1;
    end
  end

  sample_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (capture),
    .pop_i   (pop),
    .din_i   (sensor_data),
    .dout_o  (tx_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_sensor_sample_ctrl.sv
// Scoreboard bench for sensor_sample_ctrl with SAMPLE_PERIOD=8, SETTLE_CYCLES=2, FIFO_DEPTH=4.
module tb_sensor_sample_ctrl;

  logic       clk, rst, start, sensor_en, tx_valid, tx_ready, alarm, overflow, busy;
  logic [7:0] sensor_data, threshold, tx_data;

  int         n_cmp = 0;
  int         n_mis = 0;
  logic [7:0] sb[$];

  sensor_sample_ctrl #(
    .SAMPLE_PERIOD (8),
    .SETTLE_CYCLES (2),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .sensor_en   (sensor_en),
    .sensor_data (sensor_data),
    .threshold   (threshold),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .alarm       (alarm),
    .overflow    (overflow),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a handshake visible at the falling edge is the pop on the next rising edge.
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_mis++;
        $display("FAIL pop_unexpected: got %0h expected none at %0t", tx_data, $time);
      end else begin
        logic [7:0] exp;
        exp = sb.pop_front();
        if (tx_data !== exp) begin
          n_mis++;
          $display("FAIL pop_data: got %0h expected %0h at %0t", tx_data, exp, $time);
        end
      end
    end
  end

  initial begin
    int en_w[4];
    int tv_w[4];
    logic [7:0] d[5];

    rst = 1'b1; start = 1'b0; sensor_data = 8'h00; threshold = 8'h00; tx_ready = 1'b0;
    #1;
    check("rst_sensor_en", sensor_en, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_alarm", alarm, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
    step(); step();
    rst = 1'b0;

    // Periodic sampling, then start dropped in SETTLE of the third sample.
    sb.push_back(8'h5F); sb.push_back(8'h5F); sb.push_back(8'h5F);
    sensor_data = 8'h5F; tx_ready = 1'b1;
    step(); start = 1'b1;
    for (int w = 0; w < 4; w++) begin en_w[w] = 0; tv_w[w] = 0; end
    for (int c = 1; c <= 41; c++) begin
      int w;
      step();
      if (c == 17) start = 1'b0;
      @(negedge clk);
      w = (c <= 8) ? 0 : (c <= 16) ? 1 : (c <= 24) ? 2 : 3;
      en_w[w] += int'(sensor_en);
      tv_w[w] += int'(tx_valid);
      if (c == 24) check("stop_busy_in_wait", busy, 1);
      if (c == 25) check("stop_busy_fell", busy, 0);
    end
    check("period1_en_cycles", en_w[0], 3);
    check("period2_en_cycles", en_w[1], 3);
    check("period3_en_cycles", en_w[2], 3);
    check("after_stop_en_cycles", en_w[3], 0);
    check("period1_valid_cycles", tv_w[0], 1);
    check("period2_valid_cycles", tv_w[1], 1);
    check("period3_valid_cycles", tv_w[2], 1);

    // Alarm: threshold 0x50 against 0x0F, 0x50, 0xFF.
    sb.push_back(8'h0F); sb.push_back(8'h50); sb.push_back(8'hFF);
    threshold = 8'h50; sensor_data = 8'h0F;
    step(); start = 1'b1;
    for (int c = 1; c <= 28; c++) begin
      step();
      if (c == 5)  sensor_data = 8'h50;
      if (c == 13) sensor_data = 8'hFF;
      if (c == 17) start = 1'b0;
      @(negedge clk);
      if (c == 3)  check("alarm_holds_prev", alarm, 1);
      if (c == 4)  check("alarm_0F", alarm, 0);
      if (c == 11) check("alarm_holds_0", alarm, 0);
      if (c == 12) check("alarm_50", alarm, 1);
      if (c == 20) check("alarm_FF", alarm, 1);
      if (c == 28) check("alarm_run_idle", busy, 0);
    end

    // Overflow: five samples into a four-entry buffer with no consumer.
    d[0] = 8'h00; d[1] = 8'h0F; d[2] = 8'h50; d[3] = 8'h5F; d[4] = 8'hFF;
    sb.push_back(8'h00); sb.push_back(8'h0F); sb.push_back(8'h50); sb.push_back(8'h5F);
    tx_ready = 1'b0; sensor_data = d[0];
    step(); start = 1'b1;
    for (int c = 1; c <= 42; c++) begin
      step();
      if (c % 8 == 5 && c < 36) sensor_data = d[c / 8 + 1];
      if (c == 33) start = 1'b0;
      @(negedge clk);
      if (c == 28) check("ovf_before_5th", overflow, 0);
      if (c == 36) check("ovf_after_5th", overflow, 1);
      if (c == 42) check("ovf_full_valid", tx_valid, 1);
    end
    tx_ready = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      @(negedge clk);
    end
    check("ovf_drained_valid", tx_valid, 0);
    check("ovf_sticky", overflow, 1);

    // Asynchronous reset in the middle of CAPTURE.
    tx_ready = 1'b0; sensor_data = 8'h77;
    step(); start = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step();
      @(negedge clk);
    end
    check("pre_rst_sensor_en", sensor_en, 1);
    #1 rst = 1'b1;
    #1;
    check("arst_sensor_en", sensor_en, 0);
    check("arst_tx_valid", tx_valid, 0);
    check("arst_alarm", alarm, 0);
    check("arst_overflow", overflow, 0);
    check("arst_busy", busy, 0);
    start = 1'b0;
    #1 rst = 1'b0;
    for (int c = 1; c <= 10; c++) step();
    @(negedge clk);
    check("arst_no_push", tx_valid, 0);

    // Push/pop collision on the capture edge of a full buffer.
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44; d[4] = 8'h55;
    for (int i = 0; i < 5; i++) sb.push_back(d[i]);
    sensor_data = d[0];
    step(); start = 1'b1;
    for (int c = 1; c <= 46; c++) begin
      step();
      if (c % 8 == 5 && c < 36) sensor_data = d[c / 8 + 1];
      if (c == 33) start = 1'b0;
      if (c == 35) tx_ready = 1'b1;
      if (c == 36) tx_ready = 1'b0;
      if (c == 40) tx_ready = 1'b1;
      @(negedge clk);
      if (c == 36) check("coll_overflow", overflow, 0);
      if (c == 40) check("coll_occupied", tx_valid, 1);
      if (c == 43) check("coll_last_entry", tx_valid, 1);
      if (c == 44) check("coll_drained", tx_valid, 0);
    end

    check("sb_all_consumed", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
